alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: turns a decoded-stage instruction word plus register-file read data into `operand_a`, `operand_b` and `alu_op` for the `alu` block.
- Covers RV32I OP, OP-IMM, LUI and AUIPC.
- Single registered pipeline stage between register read and execute, with valid/ready handshakes on both sides and a skid buffer so `in_ready` is a flop.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  RV32I instruction word.
- in_pc  input  32  instruction PC.
- in_rs1_data  input  32  rs1 read value.
- in_rs2_data  input  32  rs2 read value.
- out_valid  output  1  issue bundle valid.
- out_ready  input  1  execute stage accepts.
- operand_a  output  32  ALU operand A.
- operand_b  output  32  ALU operand B.
- alu_op  output  4  ALU opcode.
- rd_addr  output  5  destination register.
- rd_we  output  1  write-back enable; 0 for illegal or rd==0.
- illegal  output  1  instruction not decodable by this stage.
- stat_issued  output  STAT_W  optional counter.
- stat_illegal  output  STAT_W  optional counter.

Behaviour:
- ALU opcode encoding (4 bits):
  - ADD=0000, SUB=0001, SLT=0010, SLTU=0011, XOR=0100
  - OR=0101, AND=0110, SLL=0111, SRL=1000, SRA=1001
  - 1010-1111 are never emitted.
- Decode (combinational on the input side, then registered):
  - OP (0110011): `a`=rs1, `b`=rs2, op from funct3. funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Every other funct7 other than 0000000 is illegal.
  - OP-IMM (0010011): `a`=rs1, `b`=sign-extended I-immediate.
  - SLLI/SRLI/SRAI: `b`={27'b0, shamt}. funct7 must be 0000000, or 0100000 for SRAI only; anything else is illegal.
  - There is no SUBI: funct3 000 is always ADD.
  - LUI (0110111): `a`=0, `b`={imm[31:12], 12'b0}, op ADD.
  - AUIPC (0010111): `a`=pc, `b`=U-immediate, op ADD.
  - Any other opcode is illegal.
- Illegal handling: `illegal`=1, `alu_op`=ADD, operands=0, `rd_we`=0. The instruction is still issued, never dropped.
- Handshake:
  - Input transfer occurs when `in_valid` & `in_ready`.
  - Output transfer occurs when `out_valid` & `out_ready`.
  - Once `out_valid` rises, all outputs hold stable until the transfer.
- Latency and throughput: accepted input appears on the outputs the next cycle (latency 1). Throughput is 1 per cycle when `out_ready` is held high.
- Buffering: output register plus one skid entry.
  - `in_ready`=!skid_full.
  - If an input is accepted while the output register is full and not draining, it goes into skid and `in_ready` drops next cycle.
  - On an output transfer with skid full, skid moves to the output register and `in_ready` rises next cycle.
- Simultaneous events:
  - Accept and drain in the same cycle with skid empty: the output register is reloaded and `out_valid` stays 1.
  - Skid full and draining: no new accept, since `in_ready` was 0.
- Ordering: strictly in order; no reordering or drops.
- Reset, applied asynchronously (also mid-transfer):
  - `out_valid`=0, `in_ready`=1, skid empty.
  - `operand_a`/`operand_b`=0, `alu_op`=ADD, `rd_addr`=0, `rd_we`=0, `illegal`=0, counters=0.
  - Any in-flight bundle is discarded.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - `stat_issued` increments on each output transfer.
  - `stat_illegal` increments on each output transfer with `illegal`=1.
  - Both saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package `alu_pkg` holds:
  - `alu_op_e` enum (10 codes above).
  - RV32I opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC).
  - funct3/funct7 constants.
  - Issue bundle struct: `a`, `b`, `op`, `rd`, `rd_we`, `illegal`.
- Sub-module `alu_issue_decode`: purely combinational, instr/pc/rs data to bundle.
- Handshake, skid and counters live in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=10, rs2=15, `out_ready`=1 → next cycle `out_valid`=1, a=0x0000000A, b=0x0000000F, op=0000, rd=3, `rd_we`=1. The `alu` block then yields 25.
- SUB 0x402081B3 then SRAI x5,x6,8 (0x40835293) back-to-back, rs1(x6)=0x01000000 → op 0001, then op 1001 with b=0x00000008; two consecutive `out_valid` cycles.
- SLTI x4,x1,-1 (0xFFF0A213) → b=0xFFFFFFFF, op=0010. LUI x7,0x12345 (0x123453B7) → a=0, b=0x12345000, op=0000.
- Illegal 0x40031293 (SLLI with funct7=0100000) → `illegal`=1, op=0000, a=b=0, `rd_we`=0. With ALU_ISSUE_STATS_EN, `stat_illegal`=1 after transfer.
- Backpressure: `out_ready`=0 while 3 instructions are offered → 2 accepted, `in_ready`=0 on cycle 3. Release `out_ready` → order preserved, `in_ready` returns 1 one cycle after the first drain.
- Assert `rst_n`=0 with skid full mid-stream → `out_valid`=0, `in_ready`=1, outputs at reset values immediately. No stale bundle appears after release.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | ALU opcode encoding, RV32I decode constants and the issue bundle type.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    alu_op_e             op;
    logic [4:0]          rd;
    logic                rd_we;
    logic                illegal;
  } issue_bundle_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_decode                                                           |
// | Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU issue bundle.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]   i_instr,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_rs1_data,
  input  logic [31:0]   i_rs2_data,
  output issue_bundle_t o_bundle
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_legal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  always_comb begin
    o_bundle    = '0;
    o_bundle.rd = i_instr[11:7];
    w_legal     = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        o_bundle.a = i_rs1_data;
        o_bundle.b = i_rs2_data;
        w_legal    = (w_funct7 == F7_ZERO) ||
                     ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
        case (w_funct3)
          F3_ADD:  o_bundle.op = (w_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  o_bundle.op = ALU_SLL;
          F3_SLT:  o_bundle.op = ALU_SLT;
          F3_SLTU: o_bundle.op = ALU_SLTU;
          F3_XOR:  o_bundle.op = ALU_XOR;
          F3_SR:   o_bundle.op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   o_bundle.op = ALU_OR;
          default: o_bundle.op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        o_bundle.a = i_rs1_data;
        o_bundle.b = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_funct3)
          F3_ADD:  o_bundle.op = ALU_ADD;
          F3_SLT:  o_bundle.op = ALU_SLT;
          F3_SLTU: o_bundle.op = ALU_SLTU;
          F3_XOR:  o_bundle.op = ALU_XOR;
          F3_OR:   o_bundle.op = ALU_OR;
          F3_AND:  o_bundle.op = ALU_AND;
          F3_SLL: begin
            o_bundle.op = ALU_SLL;
            o_bundle.b  = {27'b0, i_instr[24:20]};
            w_legal     = (w_funct7 == F7_ZERO);
          end
          default: begin
            o_bundle.op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            o_bundle.b  = {27'b0, i_instr[24:20]};
            w_legal     = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        o_bundle.b = {i_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        o_bundle.a = i_pc;
        o_bundle.b = {i_instr[31:12], 12'b0};
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal words still issue, but as a harmless ADD 0,0 with no write-back.
    if (!w_legal) begin
      o_bundle         = '0;
      o_bundle.rd      = i_instr[11:7];
      o_bundle.illegal = 1'b1;
    end
    o_bundle.rd_we = w_legal && (i_instr[11:7] != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_stage                                                            |
// | Registered ALU issue stage with skid buffer; stats via ALU_ISSUE_STATS_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_rs1_data,
  input  logic [31:0]       in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   operand_a,
  output logic [XLEN-1:0]   operand_b,
  output logic [3:0]        alu_op,
  output logic [4:0]        rd_addr,
  output logic              rd_we,
  output logic              illegal,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_illegal
);

  issue_bundle_t w_dec;
  issue_bundle_t r_out;
  issue_bundle_t r_skid;
  logic          r_out_valid;
  logic          r_in_ready;   // low exactly when the skid entry is occupied
  logic          w_in_xfer;
  logic          w_out_xfer;

  alu_issue_decode u_decode (
    .i_instr    (in_instr),
    .i_pc       (in_pc),
    .i_rs1_data (in_rs1_data),
    .i_rs2_data (in_rs2_data),
    .o_bundle   (w_dec)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (w_out_xfer || !r_out_valid) begin
      if (!r_in_ready) begin
        r_out       <= r_skid;
        r_out_valid <= 1'b1;
        r_in_ready  <= 1'b1;
      end else if (w_in_xfer) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid     <= w_dec;
      r_in_ready <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign operand_a = r_out.a;
  assign operand_b = r_out.b;
  assign alu_op    = r_out.op;
  assign rd_addr   = r_out.rd;
  assign rd_we     = r_out.rd_we;
  assign illegal   = r_out.illegal;

`ifdef ALU_ISSUE_STATS_EN
  logic [STAT_W-1:0] r_stat_issued;
  logic [STAT_W-1:0] r_stat_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued  <= '0;
      r_stat_illegal <= '0;
    end else if (w_out_xfer) begin
      if (r_stat_issued != '1) r_stat_issued <= r_stat_issued + 1'b1;
      if (r_out.illegal && (r_stat_illegal != '1)) r_stat_illegal <= r_stat_illegal + 1'b1;
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_illegal = r_stat_illegal;
`else
  assign stat_issued  = '0;
  assign stat_illegal = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue_stage                                                         |
// | Directed self-checking bench for alu_issue_stage.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
  logic [15:0] stat_issued;
  logic [15:0] stat_illegal;

  int vectors     = 0;
  int miscompares = 0;

  alu_issue_stage #(.XLEN(32), .STAT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_op       (alu_op),
    .rd_addr      (rd_addr),
    .rd_we        (rd_we),
    .illegal      (illegal),
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2);
    in_valid    = v;
    in_instr    = instr;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  task automatic chk_bundle(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".a"}, operand_a, a);
    chk({tag, ".b"}, operand_b, b);
    chk({tag, ".op"}, {28'b0, alu_op}, {28'b0, op});
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_pc     = 32'h0000_1000;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.a", operand_a, 32'd0);
    chk("rst.op", {28'b0, alu_op}, 32'd0);
    chk("rst.rd_we", {31'b0, rd_we}, 32'd0);
    chk("rst.illegal", {31'b0, illegal}, 32'd0);
    chk("rst.stat_issued", {16'b0, stat_issued}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'd10, 32'd15);
    cycle();
    chk_bundle("add", 32'h0000000A, 32'h0000000F, 4'b0000);
    chk("add.rd", {27'b0, rd_addr}, 32'd3);
    chk("add.rd_we", {31'b0, rd_we}, 32'd1);
    chk("add.sum", operand_a + operand_b, 32'd25);

    // SUB then SRAI back-to-back
    drive(1'b1, 32'h402081B3, 32'd10, 32'd15);
    cycle();
    chk_bundle("sub", 32'h0000000A, 32'h0000000F, 4'b0001);
    drive(1'b1, 32'h40835293, 32'h01000000, 32'd0);
    cycle();
    chk_bundle("srai", 32'h01000000, 32'h00000008, 4'b1001);
    chk("srai.rd", {27'b0, rd_addr}, 32'd5);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("idle1.out_valid", {31'b0, out_valid}, 32'd0);

    // SLTI, LUI, then an illegal SLLI encoding
    drive(1'b1, 32'hFFF0A213, 32'd10, 32'd0);
    cycle();
    chk_bundle("slti", 32'h0000000A, 32'hFFFFFFFF, 4'b0010);
    chk("slti.rd", {27'b0, rd_addr}, 32'd4);
    drive(1'b1, 32'h123453B7, 32'hDEADBEEF, 32'h0);
    cycle();
    chk_bundle("lui", 32'h00000000, 32'h12345000, 4'b0000);
    chk("lui.rd", {27'b0, rd_addr}, 32'd7);
    drive(1'b1, 32'h40031293, 32'h55555555, 32'h0);
    cycle();
    chk_bundle("ill", 32'h0, 32'h0, 4'b0000);
    chk("ill.illegal", {31'b0, illegal}, 32'd1);
    chk("ill.rd_we", {31'b0, rd_we}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
`ifdef ALU_ISSUE_STATS_EN
    chk("stat.illegal", {16'b0, stat_illegal}, 32'd1);
    chk("stat.issued", {16'b0, stat_issued}, 32'd6);
`else
    chk("stat.illegal", {16'b0, stat_illegal}, 32'd0);
    chk("stat.issued", {16'b0, stat_issued}, 32'd0);
`endif

    // Backpressure: three offers with the consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h111, 32'h1);
    cycle();
    chk("bp1.in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp1.a", operand_a, 32'h111);
    drive(1'b1, 32'h002081B3, 32'h222, 32'h1);
    cycle();
    chk("bp2.in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp2.a", operand_a, 32'h111);
    drive(1'b1, 32'h002081B3, 32'h333, 32'h1);
    cycle();
    chk("bp3.in_ready", {31'b0, in_ready}, 32'd0);
    chk_bundle("bp3.hold", 32'h111, 32'h1, 4'b0000);
    out_ready = 1'b1;
    cycle();
    chk("bp4.a", operand_a, 32'h222);
    chk("bp4.in_ready", {31'b0, in_ready}, 32'd1);
    cycle();
    chk("bp5.a", operand_a, 32'h333);
    chk("bp5.out_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("bp6.out_valid", {31'b0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    chk("bp.stat_issued", {16'b0, stat_issued}, 32'd9);
`else
    chk("bp.stat_issued", {16'b0, stat_issued}, 32'd0);
`endif

    // Asynchronous reset with the skid entry occupied
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h444, 32'h2);
    cycle();
    drive(1'b1, 32'h002081B3, 32'h555, 32'h2);
    cycle();
    chk("pre_rst.in_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst.a", operand_a, 32'd0);
    chk("arst.b", operand_b, 32'd0);
    chk("arst.rd", {27'b0, rd_addr}, 32'd0);
    chk("arst.stat_issued", {16'b0, stat_issued}, 32'd0);
    cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_rst1.out_valid", {31'b0, out_valid}, 32'd0);
    cycle();
    chk("post_rst2.out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst2.in_ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
